// File: rtl/vga_scene_gen.sv
// rtl/vga_scene_gen.sv - VGA timing generator with COVER/PLAY/OVER scene sequencer
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   start        start/restart request (single-cycle pulse)
//   fin          game-finished request (pulse or level)
//   game_rgb     {R,G,B} from the renderer for the current pix_x/pix_y
//   pix_x/pix_y  registered horizontal/vertical counts
//   pix_de       pix_x/pix_y inside the active area
//   frame_start  one-cycle pulse at h=0, v=V_ACTIVE (start of vertical blank)
//   scene        0 = COVER, 1 = PLAY, 2 = OVER
//   R/G/B        registered colour outputs, one cycle behind pix_x/pix_y
//   HS/VS        registered sync outputs, aligned with R/G/B
//
// Optional feature macro: TITLE_BLINK_EN (cover title box blinks every 32 frames).
module vga_scene_gen #(
    parameter int COLOR_W   = 4,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int BORDER    = 8,
    parameter int TITLE_W   = 256,
    parameter int TITLE_H   = 64,
    parameter int OVER_HOLD = 60
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic                                                fin,
    input  logic [3*COLOR_W-1:0]                                game_rgb,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        pix_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        pix_y,
    output logic                                                pix_de,
    output logic                                                frame_start,
    output logic [1:0]                                          scene,
    output logic [COLOR_W-1:0]                                  R,
    output logic [COLOR_W-1:0]                                  G,
    output logic [COLOR_W-1:0]                                  B,
    output logic                                                HS,
    output logic                                                VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam int BX0 = (H_ACTIVE - TITLE_W) / 2;
    localparam int BX1 = (H_ACTIVE + TITLE_W) / 2;
    localparam int BY0 = (V_ACTIVE - TITLE_H) / 2;
    localparam int BY1 = (V_ACTIVE + TITLE_H) / 2;

    localparam int HOLD_W = (OVER_HOLD < 1) ? 1 : $clog2(OVER_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    localparam logic [3*COLOR_W-1:0] RGB_WHITE = {3*COLOR_W{1'b1}};
    localparam logic [3*COLOR_W-1:0] RGB_GREEN = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}};
    localparam logic [3*COLOR_W-1:0] RGB_RED   = {{COLOR_W{1'b1}}, {2*COLOR_W{1'b0}}};

    typedef enum logic [1:0] {
        SC_COVER = 2'd0,
        SC_PLAY  = 2'd1,
        SC_OVER  = 2'd2
    } scene_t;

    logic [HW-1:0]        h_q, h_d;
    logic [VW-1:0]        v_q, v_d;
    scene_t               scene_q, scene_d;
    logic                 start_pend_q, start_pend_d;
    logic                 fin_pend_q, fin_pend_d;
    logic [HOLD_W-1:0]    hold_q, hold_d, hold_inc;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;

    int   hx;
    int   vy;
    logic de;
    logic fs;
    logic in_border;
    logic in_box;
    logic title_on;

    assign hx = 32'(h_q);
    assign vy = 32'(v_q);

    assign de        = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    assign fs        = (hx == 0) && (vy == V_ACTIVE);
    assign in_border = (hx < BORDER) || (hx >= H_ACTIVE - BORDER) ||
                       (vy < BORDER) || (vy >= V_ACTIVE - BORDER);
    assign in_box    = (hx >= BX0) && (hx < BX1) && (vy >= BY0) && (vy < BY1);

`ifdef TITLE_BLINK_EN
    logic [4:0] blink_cnt_q, blink_cnt_d;
    logic       blink_on_q, blink_on_d;

    // blink_on flips after every 32 frame_start pulses.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (fs) begin
            blink_cnt_d = blink_cnt_q + 5'd1;
            if (blink_cnt_q == 5'd31) begin
                blink_on_d = ~blink_on_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign title_on = blink_on_q;
`else
    assign title_on = 1'b1;
`endif

    // Raster counters
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (hx == H_TOTAL - 1) begin
            h_d = '0;
            v_d = (vy == V_TOTAL - 1) ? '0 : v_q + 1'b1;
        end
    end

    // Scene sequencer: evaluated only on frame_start so the scene never
    // changes inside a visible frame. Pending flags are evaluated as they
    // stood before this cycle; a request in the frame_start cycle itself is
    // OR-ed in after the clearing and so waits for the next evaluation.
    always_comb begin
        scene_d      = scene_q;
        start_pend_d = start_pend_q;
        fin_pend_d   = fin_pend_q;
        hold_d       = hold_q;
        hold_inc     = (hold_q >= HOLD_MAX) ? hold_q : hold_q + 1'b1;
        if (fs) begin
            case (scene_q)
                SC_COVER: begin
                    if (start_pend_q) begin
                        scene_d      = SC_PLAY;
                        start_pend_d = 1'b0;
                        fin_pend_d   = 1'b0;
                        hold_d       = '0;
                    end else begin
                        fin_pend_d = 1'b0;
                    end
                end
                SC_PLAY: begin
                    if (fin_pend_q) begin
                        scene_d      = SC_OVER;
                        start_pend_d = 1'b0;
                        fin_pend_d   = 1'b0;
                        hold_d       = '0;
                    end else begin
                        start_pend_d = 1'b0;
                    end
                end
                SC_OVER: begin
                    hold_d = hold_inc;
                    if ((hold_inc >= HOLD_MAX) && start_pend_q) begin
                        scene_d      = SC_COVER;
                        start_pend_d = 1'b0;
                        fin_pend_d   = 1'b0;
                        hold_d       = '0;
                    end else begin
                        // start stays pending until the hold elapses
                        fin_pend_d = 1'b0;
                    end
                end
                default: begin
                    scene_d      = SC_COVER;
                    start_pend_d = 1'b0;
                    fin_pend_d   = 1'b0;
                    hold_d       = '0;
                end
            endcase
        end
        start_pend_d = start_pend_d | start;
        fin_pend_d   = fin_pend_d | fin;
    end

    // Pixel colour for the current counters; registered below.
    always_comb begin
        rgb_d = '0;
        if (de) begin
            case (scene_q)
                SC_COVER: begin
                    if (in_border) begin
                        rgb_d = RGB_GREEN;
                    end else if (in_box && title_on) begin
                        rgb_d = RGB_WHITE;
                    end
                end
                SC_PLAY:  rgb_d = game_rgb;
                SC_OVER:  rgb_d = in_box ? RGB_WHITE : RGB_RED;
                default:  rgb_d = '0;
            endcase
        end
    end

    always_comb begin
        hs_d = ((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
        vs_d = ((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q          <= '0;
            v_q          <= '0;
            scene_q      <= SC_COVER;
            start_pend_q <= 1'b0;
            fin_pend_q   <= 1'b0;
            hold_q       <= '0;
            rgb_q        <= '0;
            hs_q         <= ~SYNC_ACT;
            vs_q         <= ~SYNC_ACT;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            scene_q      <= scene_d;
            start_pend_q <= start_pend_d;
            fin_pend_q   <= fin_pend_d;
            hold_q       <= hold_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign pix_de      = de;
    assign frame_start = fs;
    assign scene       = scene_q;
    assign R           = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign G           = rgb_q[2*COLOR_W-1:COLOR_W];
    assign B           = rgb_q[COLOR_W-1:0];
    assign HS          = hs_q;
    assign VS          = vs_q;

endmodule
